fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit FIFO_Memory buffer. It pulls bytes from the FIFO's read port whenever the FIFO is non-empty and transmission is enabled. Each byte is serialized onto a single-wire UART line as an 8N1 frame: start bit, 8 data bits LSB first, one stop bit. It is the consumer side of the FIFO and never causes a FIFO underflow.

---
 rtl/uart_pkg.sv | 17 +
 rtl/fifo_uart_tx_if.sv | 9 +
 rtl/uart_bit_timer.sv | 23 ++
 rtl/fifo_uart_tx.sv | 83 ++++++++
 tb/tb_fifo_uart_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit drain stage and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle; master is the consumer that issues read strobes.
interface fifo_uart_tx_if;
  logic       fifo_read;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  modport master (output fifo_read, input fifo_empty, input fifo_data);
  modport slave  (input fifo_read, output fifo_empty, output fifo_data);
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: bit_end marks the last clock of each bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap; held at 0 while cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (clear || bit_end) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a FIFO read port and serializes them as 8N1 UART frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  fifo_uart_tx_if.master  fif,
  output logic            tx,
  output logic            busy,
  output logic            byte_done
);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IW-1:0]        bit_idx;
  logic                 bit_end;
  logic                 tmr_clear;

  // Timer only runs while a frame is on the wire.
  assign tmr_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    tx            = IDLE_LEVEL;
    fif.fifo_read = 1'b0;
    byte_done     = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:  if (tx_en && !fif.fifo_empty) state_nxt = FETCH;
      FETCH: begin
        fif.fifo_read = 1'b1;
        state_nxt     = LOAD;
      end
      LOAD:  state_nxt = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && bit_idx == LAST_IDX) state_nxt = STOP;
      end
      STOP: begin
        byte_done = bit_end;
        if (bit_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit index: load in LOAD, advance at each data bit end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else if (state == LOAD) begin
      shift_reg <= fif.fifo_data;
      bit_idx   <= '0;
    end else if (state == DATA && bit_end) begin
      shift_reg <= shift_reg >> 1;
      bit_idx   <= bit_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO on the read port.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_en = 1'b1;
  logic tx, busy, byte_done;

  fifo_uart_tx_if fif ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fif       (fif),
    .tx        (tx),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered data_out, underflow flag, read counter.
  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_reads = 0;
  bit underflow = 1'b0;

  assign fif.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fif.fifo_read) begin
      n_reads <= n_reads + 1;
      if (wr_ptr == rd_ptr) underflow <= 1'b1;
      else begin
        fif.fifo_data <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 1;
  endtask

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame receiver results.
  logic [9:0] r_frame;
  int r_gap, r_done_idx, r_done_cnt;
  bit r_bad, r_to;

  // Wait (bounded) for a start bit, then sample 10 bits of CPB cycles each.
  // r_gap counts tx-high cycles seen before the start bit.
  task automatic recv_frame(input int drop_at);
    logic cur;
    r_frame = '0; r_gap = 0; r_done_idx = -1; r_done_cnt = 0; r_bad = 0; r_to = 0;
    cur = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0) begin
      r_gap++;
      if (r_gap > 200) begin
        r_to = 1;
        return;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c > 0) @(negedge clk);
      if (c % CPB == 0) begin
        cur = tx;
        r_frame[c / CPB] = tx;
      end else if (tx !== cur) r_bad = 1;
      if (byte_done) begin
        r_done_cnt++;
        r_done_idx = c;
      end
      if (busy !== 1'b1) r_bad = 1;
      if (c == drop_at) tx_en = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th line bit: start, d0..d7, stop
    int         gap;
  } vec_t;

  vec_t vecs [6];

  task automatic chk_frame(input string name, input int i, input int n_reads_exp);
    chk({name, "_timeout"}, r_to, 0);
    chk({name, "_frame"}, r_frame, vecs[i].frame);
    chk({name, "_gap"}, r_gap, vecs[i].gap);
    chk({name, "_done_cnt"}, r_done_cnt, 1);
    chk({name, "_done_idx"}, r_done_idx, 10 * CPB - 1);
    chk({name, "_stable_busy"}, r_bad, 0);
    chk({name, "_reads"}, n_reads, n_reads_exp);
  endtask

  initial begin
    bit tx_hi_ok, busy_lo_ok;
    int w;

    vecs[0] = '{8'hEA, 10'b1111010100, 2};
    vecs[1] = '{8'h54, 10'b1010101000, 2};
    vecs[2] = '{8'hFF, 10'b1111111110, 3};
    vecs[3] = '{8'hE0, 10'b1111000000, 3};
    vecs[4] = '{8'hD1, 10'b1110100010, 2};
    vecs[5] = '{8'h09, 10'b1000010010, 2};

    // Reset held with a non-empty FIFO and tx_en high.
    push(vecs[0].data);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_read", fif.fifo_read, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b1;

    // Single byte.
    recv_frame(-1);
    chk_frame("single", 0, 1);

    // Burst of three queued bytes.
    @(negedge clk);
    for (int i = 1; i <= 3; i++) push(vecs[i].data);
    for (int i = 1; i <= 3; i++) begin
      recv_frame(-1);
      chk_frame($sformatf("burst%0d", i), i, 1 + i);
    end

    // Empty FIFO: nothing happens for 100 cycles.
    tx_hi_ok = 1; busy_lo_ok = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_hi_ok = 0;
      if (busy !== 1'b0) busy_lo_ok = 0;
    end
    chk("empty_tx", tx_hi_ok, 1);
    chk("empty_busy", busy_lo_ok, 1);
    chk("empty_reads", n_reads, 4);

    // tx_en dropped mid-DATA; the second byte must stay in the FIFO.
    push(vecs[4].data);
    push(8'h7C);
    recv_frame(5 * CPB);
    chk_frame("txen_drop", 4, 5);
    tx_hi_ok = 1; busy_lo_ok = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_hi_ok = 0;
      if (busy !== 1'b0) busy_lo_ok = 0;
    end
    chk("txen_off_tx", tx_hi_ok, 1);
    chk("txen_off_busy", busy_lo_ok, 1);
    chk("txen_off_reads", n_reads, 5);
    chk("txen_off_empty", fif.fifo_empty, 0);

    // Reset during data bit 3 of 8'h7C.
    tx_en = 1'b1;
    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    chk("rstmid_start_seen", (w < 200), 1);
    repeat (4 * CPB + 1) @(negedge clk);
    chk("rstmid_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_read", fif.fifo_read, 0);
    chk("rstmid_reads", n_reads, 6);
    push(vecs[5].data);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    recv_frame(-1);
    chk_frame("after_rst", 5, 7);

    // 8'h7C must not reappear.
    tx_hi_ok = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_hi_ok = 0;
    end
    chk("no_retx", tx_hi_ok, 1);
    chk("final_reads", n_reads, 7);
    chk("underflow", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
